stopwatch_upcounter: RTL and testbench
======================================

// Module: stopwatch_upcounter
// PURPOSE
//  Counts elapsed time up in m:ss (BCD). Start/stop, lap and clear are controlled by push-buttons.
//  This is the count-up counterpart of the countdown timer: same digit widths and the same
//  one-second timebase, so its outputs drive triple_sevenseg directly.
//  The block runs on the single system clock; tick_1hz is a one-cycle enable from the clock divider.
// PARAMETERS
//  MAX_MINUTES  3  minutes value at which the count saturates (full scale MAX_MINUTES:59); 0..3
// PORTS
//  clk            in   1  system clock, rising edge
//  reset          in   1  synchronous, active-high; all state cleared on the next clk edge
//  tick_1hz       in   1  one-clk-wide strobe, once per second
//  btn_start_stop in   1  level, already debounced and synchronized; acts on its rising edge
//  btn_lap        in   1  level, already debounced and synchronized; acts on its rising edge
//  btn_clear      in   1  level, already debounced and synchronized; acts on its rising edge
//  seconds_count  out  4  displayed ones-of-seconds, BCD 0..9
//  tens_count     out  4  displayed tens-of-seconds, BCD 0..5
//  minutes_count  out  2  displayed minutes, 0..MAX_MINUTES
//  running        out  1  1 in RUN or LAP
//  lap_hold       out  1  1 in LAP (display frozen)
//  at_max         out  1  1 when the live count equals MAX_MINUTES:5:9
// BEHAVIOUR
//  - Reset: state IDLE. Live count and lap snapshot are 0:00. Every output is 0. Button edge registers are cleared.
//  - Edge detect: edge = btn & ~btn_q. btn_q is registered every clk.
//    A button held high produces one event only.
//  - States: IDLE, RUN, PAUSE, LAP. Transitions use this cycle's edges; the new state is visible after the next clk edge.
//      IDLE : start_stop -> RUN
//      RUN  : start_stop -> PAUSE; lap -> LAP (snapshot <= live count)
//      LAP  : lap -> RUN (release the frozen display); start_stop -> PAUSE (display shows live count)
//      PAUSE: start_stop -> RUN; lap ignored
//      any  : clear -> IDLE, live count and snapshot <= 0:00
//  - Event priority within one cycle: clear > start_stop > lap.
//  - Counting: the live count increments on a cycle where tick_1hz=1 and the registered state is RUN or LAP.
//    * A tick in the same cycle as the start edge from IDLE/PAUSE is not counted.
//    * A tick in the same cycle as the stop edge is counted.
//    * A tick in the same cycle as clear is discarded; clear wins.
//  - Carry chain:
//    * seconds 9 -> 0 with a carry to tens.
//    * tens 5 -> 0 with a carry to minutes, only when seconds was 9.
//    * Minutes increment only on the 5:9 -> 0:0 carry.
//  - Saturation: at MAX_MINUTES:5:9, further ticks are ignored.
//    at_max=1 and the state moves to PAUSE on the same edge the count reaches max.
//    start_stop from PAUSE while at_max leaves the count unchanged; the state returns to RUN,
//    then goes back to PAUSE on the next tick.
//  - Outputs: in LAP, the display shows the snapshot; otherwise it shows the live count.
//    Output latency is one clk after the tick or edge that caused the change.
//    All outputs are registered or decoded from registered state only; no input-to-output combinational path.
//  - Arithmetic: digits never hold non-BCD values. The minutes counter never exceeds MAX_MINUTES.
// STRUCTURE
//  - Shared package stopwatch_pkg (header include): state encodings ST_IDLE/ST_RUN/ST_PAUSE/ST_LAP
//    (2-bit) and the digit limits SEC_MAX=9, TENS_MAX=5.
//  - One sub-module, bcd_upcounter #(MAX, WIDTH): clk, reset, clear, enable -> count, carry_out
//    (carry_out = enable & count==MAX). It is instantiated three times and chained by carry.
//  - The FSM, edge detectors, snapshot registers and output mux live in the top module.
// TESTING
//  1. Reset held 3 clk with random buttons -> all outputs 0, state IDLE; ticks while IDLE -> count stays 0:00.
//  2. Start edge, then 75 ticks -> display 1:15, running=1.
//     Stop edge -> 10 more ticks leave 1:15 and running=0.
//  3. From RUN at 0:20: lap edge -> display frozen at 0:20, lap_hold=1 while 7 ticks elapse.
//     Second lap edge -> display 0:27.
//  4. MAX_MINUTES=3: run to 3:59 -> at_max=1, state PAUSE.
//     Another start edge plus 3 ticks -> stays 3:59.
//  5. Same-cycle events:
//     - start+tick from IDLE -> 0:00 after one clk.
//     - stop+tick at 0:09 -> 0:10 and PAUSE.
//     - clear+start+tick in RUN -> IDLE, 0:00.
//  6. Button held high 100 clk in RUN -> exactly one transition, to PAUSE.
//     Reset asserted mid-RUN at 2:34 -> 0:00, IDLE on the next edge.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared state encodings and BCD digit limits for the m:ss count-up stopwatch.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_LAP   = 2'd3
    } state_t;

    localparam int SEC_MAX  = 9;
    localparam int TENS_MAX = 5;
    localparam int SEC_W    = 4;
    localparam int TENS_W   = 4;
    localparam int MIN_W    = 2;

    // The live count advances only in these states.
    function automatic logic is_counting(input state_t s);
        return (s == ST_RUN) || (s == ST_LAP);
    endfunction

endpackage

// File: rtl/bcd_upcounter.sv
// One wrapping decimal digit; carry_out marks the enabled step that wraps MAX back to 0.
module bcd_upcounter #(
    parameter int MAX   = 9,
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    output logic [WIDTH-1:0] count,
    output logic             carry_out
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    logic at_limit;

    assign at_limit  = (count == MAX_V);
    assign carry_out = enable & at_limit;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= at_limit ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/stopwatch_upcounter.sv
// Count-up m:ss stopwatch with start/stop, lap freeze and clear; saturates at MAX_MINUTES:59.
module stopwatch_upcounter
    import stopwatch_pkg::*;
#(
    parameter int MAX_MINUTES = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick_1hz,
    input  logic              btn_start_stop,
    input  logic              btn_lap,
    input  logic              btn_clear,
    output logic [SEC_W-1:0]  seconds_count,
    output logic [TENS_W-1:0] tens_count,
    output logic [MIN_W-1:0]  minutes_count,
    output logic              running,
    output logic              lap_hold,
    output logic              at_max
);

    localparam logic [MIN_W-1:0]  MIN_MAX_V  = MIN_W'(MAX_MINUTES);
    localparam logic [TENS_W-1:0] TENS_MAX_V = TENS_W'(TENS_MAX);
    localparam logic [SEC_W-1:0]  SEC_MAX_V  = SEC_W'(SEC_MAX);
    localparam logic [SEC_W-1:0]  SEC_PRE_V  = SEC_W'(SEC_MAX - 1);

    state_t state;
    state_t state_next;

    logic ss_q, lap_q, clr_q;
    logic ss_edge, lap_edge, clr_edge;

    logic [SEC_W-1:0]  sec_live, sec_snap;
    logic [TENS_W-1:0] tens_live, tens_snap;
    logic [MIN_W-1:0]  min_live, min_snap;

    logic sec_carry, tens_carry, min_carry;
    logic count_en, live_max, reach_max, sat_stop, snap_load;

    always_ff @(posedge clk) begin
        if (reset) begin
            ss_q  <= 1'b0;
            lap_q <= 1'b0;
            clr_q <= 1'b0;
        end else begin
            ss_q  <= btn_start_stop;
            lap_q <= btn_lap;
            clr_q <= btn_clear;
        end
    end

    assign ss_edge  = btn_start_stop & ~ss_q;
    assign lap_edge = btn_lap & ~lap_q;
    assign clr_edge = btn_clear & ~clr_q;

    assign live_max  = (min_live == MIN_MAX_V) && (tens_live == TENS_MAX_V) && (sec_live == SEC_MAX_V);
    assign reach_max = (min_live == MIN_MAX_V) && (tens_live == TENS_MAX_V) && (sec_live == SEC_PRE_V);

    // A tick is taken only in a counting state, never alongside clear, never past full scale.
    assign count_en = tick_1hz & is_counting(state) & ~clr_edge & ~live_max;

    // min_carry would mean the minutes wrapped; it cannot rise while the gate above holds,
    // but stopping on it keeps the count from ever wrapping silently.
    assign sat_stop = (count_en & reach_max) | (tick_1hz & live_max) | min_carry;

    bcd_upcounter #(.MAX(SEC_MAX), .WIDTH(SEC_W)) u_sec (
        .clk       (clk),
        .reset     (reset),
        .clear     (clr_edge),
        .enable    (count_en),
        .count     (sec_live),
        .carry_out (sec_carry)
    );

    bcd_upcounter #(.MAX(TENS_MAX), .WIDTH(TENS_W)) u_tens (
        .clk       (clk),
        .reset     (reset),
        .clear     (clr_edge),
        .enable    (sec_carry),
        .count     (tens_live),
        .carry_out (tens_carry)
    );

    bcd_upcounter #(.MAX(MAX_MINUTES), .WIDTH(MIN_W)) u_min (
        .clk       (clk),
        .reset     (reset),
        .clear     (clr_edge),
        .enable    (tens_carry),
        .count     (min_live),
        .carry_out (min_carry)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Event priority: clear, then start_stop, then saturation, then lap.
    always_comb begin
        state_next = state;
        snap_load  = 1'b0;
        if (clr_edge) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ss_edge) state_next = ST_RUN;
                end
                ST_RUN: begin
                    if (ss_edge || sat_stop) begin
                        state_next = ST_PAUSE;
                    end else if (lap_edge) begin
                        state_next = ST_LAP;
                        snap_load  = 1'b1;
                    end
                end
                ST_LAP: begin
                    if (ss_edge || sat_stop) begin
                        state_next = ST_PAUSE;
                    end else if (lap_edge) begin
                        state_next = ST_RUN;
                    end
                end
                ST_PAUSE: begin
                    if (ss_edge) state_next = ST_RUN;
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clr_edge) begin
            sec_snap  <= '0;
            tens_snap <= '0;
            min_snap  <= '0;
        end else if (snap_load) begin
            sec_snap  <= sec_live;
            tens_snap <= tens_live;
            min_snap  <= min_live;
        end
    end

    assign lap_hold      = (state == ST_LAP);
    assign running       = is_counting(state);
    assign at_max        = live_max;
    assign seconds_count = lap_hold ? sec_snap  : sec_live;
    assign tens_count    = lap_hold ? tens_snap : tens_live;
    assign minutes_count = lap_hold ? min_snap  : min_live;

endmodule

// File: tb/tb_stopwatch_upcounter.sv
// Directed bench for stopwatch_upcounter: reset, run/stop, lap, saturation, same-cycle events, held button.
module tb_stopwatch_upcounter;
    import stopwatch_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick_1hz;
    logic       btn_start_stop;
    logic       btn_lap;
    logic       btn_clear;
    logic [3:0] seconds_count;
    logic [3:0] tens_count;
    logic [1:0] minutes_count;
    logic       running;
    logic       lap_hold;
    logic       at_max;

    int     total = 0;
    int     bad   = 0;
    int     trans;
    state_t prev;

    always #5 clk = ~clk;

    stopwatch_upcounter #(.MAX_MINUTES(3)) dut (
        .clk            (clk),
        .reset          (reset),
        .tick_1hz       (tick_1hz),
        .btn_start_stop (btn_start_stop),
        .btn_lap        (btn_lap),
        .btn_clear      (btn_clear),
        .seconds_count  (seconds_count),
        .tens_count     (tens_count),
        .minutes_count  (minutes_count),
        .running        (running),
        .lap_hold       (lap_hold),
        .at_max         (at_max)
    );

    // Inputs change and outputs are sampled 1 ns after the rising edge.
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_disp(input string tag, input int m, input int t, input int s);
        check({tag, ".min"},  32'(minutes_count), 32'(m));
        check({tag, ".tens"}, 32'(tens_count),    32'(t));
        check({tag, ".sec"},  32'(seconds_count), 32'(s));
    endtask

    task automatic check_state(input string tag, input state_t exp);
        check({tag, ".state"}, 32'(dut.state), 32'(exp));
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            tick_1hz = 1'b1;
            cyc(1);
            tick_1hz = 1'b0;
            cyc(1);
        end
    endtask

    // which: 0 start_stop, 1 lap, 2 clear
    task automatic press(input int which);
        case (which)
            0: btn_start_stop = 1'b1;
            1: btn_lap = 1'b1;
            default: btn_clear = 1'b1;
        endcase
        cyc(1);
        btn_start_stop = 1'b0;
        btn_lap        = 1'b0;
        btn_clear      = 1'b0;
        cyc(1);
    endtask

    initial begin
        reset          = 1'b1;
        tick_1hz       = 1'b0;
        btn_start_stop = 1'b0;
        btn_lap        = 1'b0;
        btn_clear      = 1'b0;

        // 1. reset with random buttons, then idle ticks
        for (int i = 0; i < 3; i++) begin
            btn_start_stop = 1'($urandom_range(0, 1));
            btn_lap        = 1'($urandom_range(0, 1));
            btn_clear      = 1'($urandom_range(0, 1));
            tick_1hz       = 1'($urandom_range(0, 1));
            cyc(1);
        end
        check_disp("reset", 0, 0, 0);
        check("reset.running", 32'(running), 0);
        check("reset.lap_hold", 32'(lap_hold), 0);
        check("reset.at_max", 32'(at_max), 0);
        check_state("reset", ST_IDLE);
        btn_start_stop = 1'b0;
        btn_lap        = 1'b0;
        btn_clear      = 1'b0;
        tick_1hz       = 1'b0;
        reset          = 1'b0;
        cyc(1);
        tick(5);
        check_disp("idle_ticks", 0, 0, 0);
        check_state("idle_ticks", ST_IDLE);

        // 2. run 75 s, stop, lap ignored in pause
        press(0);
        check_state("start", ST_RUN);
        tick(75);
        check_disp("run75", 1, 1, 5);
        check("run75.running", 32'(running), 1);
        press(0);
        check_state("stop", ST_PAUSE);
        tick(10);
        check_disp("paused", 1, 1, 5);
        check("paused.running", 32'(running), 0);
        press(1);
        check_state("pause_lap", ST_PAUSE);
        check("pause_lap.lap_hold", 32'(lap_hold), 0);

        // 3. lap freeze at 0:20, release at 0:27
        press(2);
        check_state("clear", ST_IDLE);
        check_disp("clear", 0, 0, 0);
        press(0);
        tick(20);
        check_disp("pre_lap", 0, 2, 0);
        press(1);
        check("lap.lap_hold", 32'(lap_hold), 1);
        tick(7);
        check_disp("lap_frozen", 0, 2, 0);
        check("lap_frozen.running", 32'(running), 1);
        check("lap_frozen.lap_hold", 32'(lap_hold), 1);
        press(1);
        check_disp("lap_release", 0, 2, 7);
        check("lap_release.lap_hold", 32'(lap_hold), 0);
        check_state("lap_release", ST_RUN);

        // 4. saturation at 3:59 (239 s total, 27 already elapsed)
        tick(211);
        check_disp("pre_max", 3, 5, 8);
        check("pre_max.at_max", 32'(at_max), 0);
        check_state("pre_max", ST_RUN);
        tick(1);
        check_disp("max", 3, 5, 9);
        check("max.at_max", 32'(at_max), 1);
        check_state("max", ST_PAUSE);
        press(0);
        check_state("max_restart", ST_RUN);
        tick(1);
        check_state("max_retick", ST_PAUSE);
        tick(2);
        check_disp("max_hold", 3, 5, 9);
        check("max_hold.at_max", 32'(at_max), 1);

        // 5. same-cycle events
        press(2);
        check("clr_max.at_max", 32'(at_max), 0);
        btn_start_stop = 1'b1;
        tick_1hz       = 1'b1;
        cyc(1);
        btn_start_stop = 1'b0;
        tick_1hz       = 1'b0;
        check_disp("start_tick", 0, 0, 0);
        check_state("start_tick", ST_RUN);
        cyc(1);
        tick(9);
        check_disp("pre_stop_tick", 0, 0, 9);
        btn_start_stop = 1'b1;
        tick_1hz       = 1'b1;
        cyc(1);
        btn_start_stop = 1'b0;
        tick_1hz       = 1'b0;
        check_disp("stop_tick", 0, 1, 0);
        check_state("stop_tick", ST_PAUSE);
        cyc(1);
        press(0);
        check_state("resume", ST_RUN);
        btn_clear      = 1'b1;
        btn_start_stop = 1'b1;
        tick_1hz       = 1'b1;
        cyc(1);
        btn_clear      = 1'b0;
        btn_start_stop = 1'b0;
        tick_1hz       = 1'b0;
        check_disp("clr_start_tick", 0, 0, 0);
        check_state("clr_start_tick", ST_IDLE);
        cyc(1);

        // 6. held button gives one event; reset mid-run
        press(0);
        tick(3);
        check_disp("pre_hold", 0, 0, 3);
        trans          = 0;
        prev           = dut.state;
        btn_start_stop = 1'b1;
        for (int i = 0; i < 100; i++) begin
            cyc(1);
            if (dut.state !== prev) trans++;
            prev = dut.state;
        end
        btn_start_stop = 1'b0;
        cyc(1);
        check("hold.transitions", 32'(trans), 1);
        check_state("hold", ST_PAUSE);

        press(2);
        press(0);
        tick(154);
        check_disp("pre_reset", 2, 3, 4);
        check("pre_reset.running", 32'(running), 1);
        reset = 1'b1;
        cyc(1);
        check_disp("mid_reset", 0, 0, 0);
        check_state("mid_reset", ST_IDLE);
        check("mid_reset.running", 32'(running), 0);
        reset = 1'b0;
        cyc(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
